// File: rtl/tr_sequencer.sv
`default_nettype none
// tr_sequencer: HL2 transmit/receive sequencer with timed relay/DAC keying, inhibit and TX watchdog.
// Revision 1.0
module tr_sequencer #(
  parameter int TICK_DIV      = 77,
  parameter int PRE_TICKS     = 1000,
  parameter int POST_TICKS    = 1000,
  parameter int TIMEOUT_TICKS = 60000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_req,
  input  logic       cw_keydown,
  input  logic       tx_inhibit_n,
  input  logic       pa_enable,
  input  logic       ext_tr_enable,
  input  logic [9:0] hang_ticks,
  output logic       rfsw_sel,
  output logic       pa_inttr,
  output logic       pa_exttr,
  output logic       txquiet_n,
  output logic       tx_active,
  output logic       timeout_flag,
  output logic [2:0] state
);

  localparam int PP_MAX = (PRE_TICKS > POST_TICKS) ? PRE_TICKS : POST_TICKS;
  localparam int DW_W   = ($clog2(PP_MAX + 1) > 10) ? $clog2(PP_MAX + 1) : 10;
  localparam int WD_W   = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam int PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DW_W-1:0] PRE_LOAD  = DW_W'(PRE_TICKS);
  localparam logic [DW_W-1:0] POST_LOAD = DW_W'(POST_TICKS);
  localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT_TICKS);
  localparam logic [PS_W-1:0] TICK_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_RX      = 3'd0,
    S_ARM     = 3'd1,
    S_TX      = 3'd2,
    S_HANG    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      sync_q;
  logic [PS_W-1:0] presc;
  logic [DW_W-1:0] dwell;
  logic [DW_W-1:0] dwell_load;
  logic [WD_W-1:0] wd;
  logic [WD_W:0]   wd_next_cnt;
  logic            lockout;
  logic            inh;
  logic            req;
  logic            tick;
  logic            dwell_done;
  logic            wd_fire;
  logic            wd_clr;
  logic            fire;
  logic            keyed_d;

  assign inh         = ~sync_q[1];
  assign req         = (tx_req | cw_keydown) & ~inh & ~lockout;
  assign tick        = (presc == TICK_LAST);
  // A dwell of N ticks expires on the last clock of its Nth tick; zero expires at once.
  assign dwell_done  = (dwell == '0) || (tick && (dwell == DW_W'(1)));
  assign wd_next_cnt = {1'b0, wd} + {{WD_W{1'b0}}, tick};
  assign wd_fire     = (TIMEOUT_TICKS != 0) && (wd_next_cnt >= {1'b0, WD_LIMIT});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], tx_inhibit_n};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RX;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wd_clr  = 1'b0;
    fire    = 1'b0;
    case (state_q)
      S_RX: begin
        if (req) state_d = S_ARM;
      end
      S_ARM: begin
        if (!req) begin
          state_d = S_RELEASE;
        end else if (dwell_done) begin
          state_d = S_TX;
          wd_clr  = 1'b1;
        end
      end
      S_TX: begin
        if (inh) begin
          state_d = S_RELEASE;
        end else if (wd_fire) begin
          state_d = S_RELEASE;
          fire    = 1'b1;
        end else if (!req) begin
          state_d = S_HANG;
        end
      end
      S_HANG: begin
        if (inh) begin
          state_d = S_RELEASE;
        end else if (wd_fire) begin
          state_d = S_RELEASE;
          fire    = 1'b1;
        end else if (req) begin
          state_d = S_TX;
        end else if (dwell_done) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (dwell_done) state_d = S_RX;
      end
      default: state_d = S_RX;
    endcase
  end

  always_comb begin
    dwell_load = '0;
    case (state_d)
      S_ARM:     dwell_load = PRE_LOAD;
      S_HANG:    dwell_load = DW_W'(hang_ticks);
      S_RELEASE: dwell_load = POST_LOAD;
      default:   dwell_load = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      dwell <= '0;
    end else if (state_d != state_q) begin
      presc <= '0;
      dwell <= dwell_load;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick && (dwell != '0)) dwell <= dwell - 1'b1;
    end
  end

  // Watchdog survives HANG->TX so a chopped key cannot extend the transmit limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd <= '0;
    end else if (wd_clr) begin
      wd <= '0;
    end else if (tick && (state_q == S_TX || state_q == S_HANG) && (wd < WD_LIMIT)) begin
      wd <= wd + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lockout <= 1'b0;
    end else if (fire) begin
      lockout <= 1'b1;
    end else if (state_q == S_RX && !tx_req && !cw_keydown) begin
      lockout <= 1'b0;
    end
  end

  assign keyed_d = (state_d == S_ARM) || (state_d == S_TX) || (state_d == S_HANG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rfsw_sel  <= 1'b0;
      pa_inttr  <= 1'b0;
      pa_exttr  <= 1'b0;
      txquiet_n <= 1'b0;
      tx_active <= 1'b0;
    end else begin
      rfsw_sel  <= keyed_d;
      pa_inttr  <= keyed_d & pa_enable;
      pa_exttr  <= keyed_d & ext_tr_enable;
      txquiet_n <= (state_d == S_TX);
      tx_active <= (state_d == S_TX);
    end
  end

  assign timeout_flag = lockout;
  assign state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_tr_sequencer.sv
`default_nettype none
// tb_tr_sequencer: directed scenarios with a timing-level reference model checked every cycle.
// Revision 1.0
module tb_tr_sequencer;

  localparam int TD   = 4;
  localparam int PRE  = 3;
  localparam int POST = 2;
  localparam int TO   = 50;
  localparam int HANG = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_req, cw_keydown, tx_inhibit_n, pa_enable, ext_tr_enable;
  logic [9:0] hang_ticks;
  logic       rfsw_sel, pa_inttr, pa_exttr, txquiet_n, tx_active, timeout_flag;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  tr_sequencer #(
    .TICK_DIV(TD), .PRE_TICKS(PRE), .POST_TICKS(POST), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_req(tx_req), .cw_keydown(cw_keydown),
    .tx_inhibit_n(tx_inhibit_n), .pa_enable(pa_enable), .ext_tr_enable(ext_tr_enable),
    .hang_ticks(hang_ticks), .rfsw_sel(rfsw_sel), .pa_inttr(pa_inttr), .pa_exttr(pa_exttr),
    .txquiet_n(txquiet_n), .tx_active(tx_active), .timeout_flag(timeout_flag), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: mode plus clocks elapsed in the current mode and ticks spent keyed in TX.
  int   m_mode, m_cnt, m_wd, m_nxt, m_wd_now;
  bit   m_lock, m_s1, m_s2, m_inh, m_tick, m_req, m_fire;
  logic [8:0] exp_vec;
  int   rf_cnt = 0;
  bit   tq_prev = 1'b0;

  function automatic int dwell_clocks(input int n);
    return (n == 0) ? 1 : n * TD;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_wd = 0; m_lock = 0; m_s1 = 1; m_s2 = 1;
    end else begin
      m_inh    = !m_s2;
      m_tick   = (m_cnt % TD) == (TD - 1);
      m_req    = (tx_req || cw_keydown) && !m_inh && !m_lock;
      m_wd_now = m_wd + (((m_mode == 2 || m_mode == 3) && m_tick) ? 1 : 0);
      m_nxt    = m_mode;
      m_fire   = 0;
      case (m_mode)
        0: if (m_req) m_nxt = 1;
        1: if (!m_req) m_nxt = 4;
           else if (m_cnt + 1 >= dwell_clocks(PRE)) m_nxt = 2;
        2: if (m_inh) m_nxt = 4;
           else if (m_wd_now >= TO) begin m_nxt = 4; m_fire = 1; end
           else if (!m_req) m_nxt = 3;
        3: if (m_inh) m_nxt = 4;
           else if (m_wd_now >= TO) begin m_nxt = 4; m_fire = 1; end
           else if (m_req) m_nxt = 2;
           else if (m_cnt + 1 >= dwell_clocks(int'(hang_ticks))) m_nxt = 4;
        default: if (m_cnt + 1 >= dwell_clocks(POST)) m_nxt = 0;
      endcase
      if (m_fire) m_lock = 1;
      else if (m_mode == 0 && !tx_req && !cw_keydown) m_lock = 0;
      m_wd  = (m_mode == 1 && m_nxt == 2) ? 0 : ((m_wd_now > TO) ? TO : m_wd_now);
      m_cnt = (m_nxt != m_mode) ? 0 : m_cnt + 1;
      m_s2  = m_s1;
      m_s1  = tx_inhibit_n;
      m_mode = m_nxt;
    end
    exp_vec[8:6] = 3'(m_mode);
    exp_vec[5]   = rst_n && (m_mode >= 1 && m_mode <= 3);
    exp_vec[4]   = exp_vec[5] && pa_enable;
    exp_vec[3]   = exp_vec[5] && ext_tr_enable;
    exp_vec[2]   = rst_n && (m_mode == 2);
    exp_vec[1]   = exp_vec[2];
    exp_vec[0]   = m_lock;
    #1;
    check("cycle_outputs",
          {23'd0, state, rfsw_sel, pa_inttr, pa_exttr, txquiet_n, tx_active, timeout_flag},
          {23'd0, exp_vec});
    rf_cnt = rfsw_sel ? rf_cnt + 1 : 0;
    if (txquiet_n && !tq_prev)
      check("relay_settled_before_tx", 32'(rf_cnt > PRE * TD), 32'd1);
    tq_prev = txquiet_n;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit: got timeout, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 0; tx_req = 0; cw_keydown = 0; tx_inhibit_n = 1;
    pa_enable = 1; ext_tr_enable = 0; hang_ticks = 10'(HANG);
    step(2);
    check("reset_state", {29'd0, state}, 32'd0);
    check("reset_outputs", {26'd0, rfsw_sel, pa_inttr, pa_exttr, txquiet_n, tx_active, timeout_flag}, 32'd0);
    rst_n = 1;
    step(3);

    // 1: basic key-up / key-down timing
    tx_req = 1;
    step(1);
    check("s1_arm_relays", {29'd0, rfsw_sel, pa_inttr, pa_exttr}, 32'b110);
    check("s1_arm_state", {29'd0, state}, 32'd1);
    step(11);
    check("s1_no_tx_edge12", {31'd0, txquiet_n}, 32'd0);
    step(1);
    check("s1_tx_edge13", {30'd0, txquiet_n, tx_active}, 32'b11);
    pa_enable = 0;
    step(1);
    check("s1_pa_disable", {30'd0, rfsw_sel, pa_inttr}, 32'b10);
    pa_enable = 1; ext_tr_enable = 1;
    step(1);
    check("s1_ext_enable", {30'd0, pa_inttr, pa_exttr}, 32'b11);
    ext_tr_enable = 0;
    step(1);
    tx_req = 0;
    step(1);
    check("s1_hang_entry", {28'd0, state, txquiet_n}, {28'd0, 3'd3, 1'b0});
    step(19);
    check("s1_hang_relays_held", {31'd0, rfsw_sel}, 32'd1);
    step(1);
    check("s1_release", {28'd0, state, rfsw_sel}, {28'd0, 3'd4, 1'b0});
    step(7);
    check("s1_release_hold", {29'd0, state}, 32'd4);
    step(1);
    check("s1_back_rx", {29'd0, state}, 32'd0);
    step(3);

    // 2: CW gap absorbed in HANG
    cw_keydown = 1;
    step(13);
    check("s2_tx", {29'd0, state}, 32'd2);
    step(4);
    cw_keydown = 0;
    step(12);
    check("s2_gap_hang", {28'd0, state, rfsw_sel}, {28'd0, 3'd3, 1'b1});
    cw_keydown = 1;
    step(1);
    check("s2_rekey_tx", {28'd0, state, txquiet_n}, {28'd0, 3'd2, 1'b1});
    cw_keydown = 0;
    step(30);
    check("s2_rx", {29'd0, state}, 32'd0);

    // 3: external inhibit
    tx_req = 1;
    step(13);
    step(3);
    tx_inhibit_n = 0;
    step(2);
    check("s3_sync_latency", {31'd0, txquiet_n}, 32'd1);
    step(1);
    check("s3_release", {28'd0, state, txquiet_n}, {28'd0, 3'd4, 1'b0});
    step(8);
    check("s3_rx", {29'd0, state}, 32'd0);
    step(20);
    check("s3_blocked", {28'd0, state, rfsw_sel}, 32'd0);
    tx_inhibit_n = 1;
    step(2);
    check("s3_still_rx", {29'd0, state}, 32'd0);
    step(1);
    check("s3_arm_after_inhibit", {29'd0, state}, 32'd1);
    tx_req = 0;
    step(10);

    // 4: watchdog
    tx_req = 1;
    step(13);
    check("s4_tx", {29'd0, state}, 32'd2);
    step(199);
    check("s4_tx_199", {30'd0, state == 3'd2, timeout_flag}, 32'b10);
    step(1);
    check("s4_timeout", {28'd0, state, timeout_flag}, {28'd0, 3'd4, 1'b1});
    step(8);
    check("s4_rx_locked", {28'd0, state, timeout_flag}, {28'd0, 3'd0, 1'b1});
    step(10);
    check("s4_no_rearm", {28'd0, state, rfsw_sel}, 32'd0);
    tx_req = 0;
    step(1);
    check("s4_flag_clear", {31'd0, timeout_flag}, 32'd0);
    tx_req = 1;
    step(1);
    check("s4_rearm", {29'd0, state}, 32'd1);
    tx_req = 0;
    step(10);

    // 5: abort in ARM, re-request during RELEASE
    tx_req = 1;
    step(5);
    tx_req = 0;
    step(1);
    check("s5_arm_abort", {28'd0, state, txquiet_n}, {28'd0, 3'd4, 1'b0});
    step(2);
    tx_req = 1;
    step(5);
    check("s5_release_runs", {29'd0, state}, 32'd4);
    step(1);
    check("s5_rx", {29'd0, state}, 32'd0);
    step(1);
    check("s5_arm", {29'd0, state}, 32'd1);
    step(12);
    check("s5_tx", {29'd0, state}, 32'd2);
    step(3);

    // 6: asynchronous reset mid-TX
    rst_n = 0; tx_req = 0;
    #1;
    check("s6_async_reset", {23'd0, state, rfsw_sel, pa_inttr, pa_exttr, txquiet_n, tx_active, timeout_flag}, 32'd0);
    step(2);
    rst_n = 1;
    step(2);
    tx_req = 1;
    step(1);
    check("s6_arm", {28'd0, state, rfsw_sel}, {28'd0, 3'd1, 1'b1});
    step(12);
    check("s6_tx", {28'd0, state, txquiet_n}, {28'd0, 3'd2, 1'b1});
    tx_req = 0;
    step(30);
    check("s6_rx", {29'd0, state}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
